dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's data-memory port: services CPU load/store
//  requests (MemRead/MemWrite, Address, WriteData) from EX_MEM with programmable latency.
//  Holds the pipeline with stall_o while a request is pending.
//  Sits in place of the zero-latency data memory, between EX_MEM outputs and MEM_WB ReadData.
// PARAMETERS
//  DEPTH  32  number of 32-bit words in the internal array (power of 2, 4..1024)
//  LAT    2   cycles from request capture to response (1..15)
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   asynchronous, active-low reset
//  MemRead_i    in   1   load request
//  MemWrite_i   in   1   store request
//  Address_i    in   32  byte address (word-aligned required)
//  WriteData_i  in   32  store data
//  data_o       out  32  load data; valid while ack_o=1, held until next ack
//  stall_o      out  1   freeze PC/IF_ID/ID_EX/EX_MEM; combinational
//  ack_o        out  1   one-cycle pulse: request completed this cycle
//  err_o        out  1   with ack_o: request rejected (no memory side effect)
// BEHAVIOUR
//  - Reset (rst_i=0, async): state=IDLE, cnt=0, data_o=0, ack_o=0, err_o=0. Array not cleared.
//  - req = MemRead_i | MemWrite_i. FSM states are IDLE, WAIT and DONE:
//    IDLE: if req -> latch op/addr/wdata, cnt=LAT-1; next DONE if LAT==1, else WAIT.
//    WAIT: cnt decrements each cycle; when cnt==1 -> DONE.
//    DONE: ack_o=1 (registered), data_o valid; always -> IDLE.
//  - stall_o = (IDLE & req) | WAIT. stall_o is 0 in DONE, so the pipeline advances on that edge.
//    Request arrives at cycle 0; ack_o is high in cycle LAT; the stall covers cycles 0..LAT-1.
//  - Request inputs are sampled only in IDLE. Changes during WAIT/DONE are ignored.
//  - A request present in the IDLE cycle after DONE is a new request, even if identical.
//    Back-to-back throughput is 1 per LAT+1 cycles.
//  - Store: array[addr[AW+1:2]] <= wdata on the clock edge ending the DONE cycle.
//    On a store ack, data_o retains its previous value.
//  - Load: data_o <= array[addr] registered into DONE. A load sees any store completed earlier.
//  - Errors (err_o=1 with ack_o, no write, data_o=0):
//    MemRead_i & MemWrite_i both set; Address_i[1:0]!=0; Address_i[31:2] >= DEPTH.
//    Errors use the same latency as normal requests.
//  - AW = clog2(DEPTH). Only word accesses are supported; there are no byte enables.
//  - Reset mid-request aborts it: no write, no ack, stall_o drops to 0 while rst_i=0.
//  - No X propagation: with no request in IDLE, stall_o=0 and ack_o=0.
// TESTING
//  1. LAT=2: store 0xDEADBEEF @0x10. stall_o=1 cycles 0-1, ack cycle 2, err_o=0.
//     Then load @0x10 -> data_o=0xDEADBEEF at ack.
//  2. LAT=1 and LAT=5: a single load shows stall for exactly LAT cycles and ack in cycle LAT.
//     Back-to-back loads ack every LAT+1 cycles.
//  3. Misaligned @0x13, out-of-range @0x80 (DEPTH=32), and Read+Write together:
//     each gives ack with err_o=1 and data_o=0. A following load of the target word is unchanged.
//  4. Change Address_i/WriteData_i during WAIT: the write goes to the originally latched
//     address and data only.
//  5. Assert rst_i=0 during WAIT of a store to @0x4 (old 0x11111111): outputs zero at once.
//     After release, a load @0x4 returns 0x11111111.
//  6. Idle with MemRead_i=MemWrite_i=0 for 10 cycles: stall_o, ack_o and err_o stay 0.
//     data_o holds the last load value.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable latency: captures one load/store in IDLE,
// stalls the pipeline while it is pending, then acks (with err_o on rejected requests).
module dmem_responder #(
    parameter int DEPTH = 32,
    parameter int LAT   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic            bad_q, bad_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_q, data_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            stall_raw;

    logic [31:0]     mem [DEPTH];

    logic            req;
    logic            req_bad;
    logic [AW-1:0]   req_idx;

    assign req     = MemRead_i | MemWrite_i;
    assign req_bad = (MemRead_i & MemWrite_i)
                   | (Address_i[1:0] != 2'b00)
                   | (Address_i[31:2] >= 30'(DEPTH));
    assign req_idx = Address_i[AW+1:2];

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        bad_d     = bad_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        stall_raw = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    stall_raw = 1'b1;
                    wr_d      = MemWrite_i;
                    bad_d     = req_bad;
                    idx_d     = req_idx;
                    wdata_d   = WriteData_i;
                    cnt_d     = 4'(LAT - 1);
                    state_d   = (LAT == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall_raw = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The _d copies already hold the live request when LAT==1 jumps straight from IDLE.
        if (state_d == DONE) begin
            ack_d = 1'b1;
            err_d = bad_d;
            if (bad_d) begin
                data_d = '0;
            end else if (!wr_d) begin
                data_d = mem[idx_d];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            bad_q   <= bad_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset; its contents survive rst_i and reset forces IDLE, so no write fires.
    always_ff @(posedge clk_i) begin
        if (state_q == DONE && wr_q && !bad_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign stall_o = stall_raw & rst_i;
    assign data_o  = data_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LAT=2, 1, 5) driven with directed
// vectors; a monitor pops the expected response on every ack.
module tb_dmem_responder;

    typedef struct {
        int          k;
        int          cyc;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    logic [2:0]  rd, wr, stall, ack, err;
    logic [31:0] addr [3];
    logic [31:0] wdat [3];
    logic [31:0] dout [3];
    logic [31:0] last_d [3];
    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH(32),
            .LAT  ((g == 0) ? 2 : ((g == 1) ? 1 : 5))
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst_n),
            .MemRead_i  (rd[g]),
            .MemWrite_i (wr[g]),
            .Address_i  (addr[g]),
            .WriteData_i(wdat[g]),
            .data_o     (dout[g]),
            .stall_o    (stall[g]),
            .ack_o      (ack[g]),
            .err_o      (err[g])
        );
    end

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Issue one request on instance k and hold it while stalled, like a frozen EX_MEM.
    task automatic xact(int k, bit r, bit w, logic [31:0] a, logic [31:0] d,
                        bit exp_e, logic [31:0] exp_d, bit wiggle = 1'b0);
        exp_t e;
        int   n = 0;
        bit   done = 1'b0;
        @(posedge clk);
        #1;
        rd = '0;
        wr = '0;
        rd[k] = r;
        wr[k] = w;
        addr[k] = a;
        wdat[k] = d;
        e.k   = k;
        e.cyc = cyc + lat_of(k);
        e.e   = exp_e;
        if (w && !r && !exp_e) begin
            e.d = last_d[k];
        end else begin
            e.d = exp_d;
            last_d[k] = exp_d;
        end
        sb.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall[k] !== 1'b1) begin
                done = 1'b1;
                break;
            end
            n++;
            if (wiggle && n == 2) begin
                addr[k] = a + 32'd4;
                wdat[k] = ~d;
            end
        end
        check("stall_done", 32'(done), 32'd1);
        check("stall_cycles", n, lat_of(k));
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ack[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(ack[k]), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_inst", k, e.k);
                    check("ack_cycle", cyc, e.cyc);
                    check("data", dout[k], e.d);
                    check("err", 32'(err[k]), 32'(e.e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rd = '0;
        wr = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0;
            wdat[k] = '0;
            last_d[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_stall", 32'(stall[k]), 32'd0);
            check("rst_ack", 32'(ack[k]), 32'd0);
            check("rst_err", 32'(err[k]), 32'd0);
            check("rst_data", dout[k], 32'd0);
        end
        rst_n = 1'b1;

        // LAT=2: store/load round trip, errors, store holds data_o.
        xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        xact(0, 1, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF);
        xact(0, 0, 1, 32'h13, 32'hBAD0BAD0, 1, 32'h0);
        xact(0, 1, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF);
        xact(0, 1, 0, 32'h80, 32'h0,        1, 32'h0);
        xact(0, 1, 1, 32'h10, 32'h12345678, 1, 32'h0);
        xact(0, 1, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF);
        xact(0, 0, 1, 32'h14, 32'h01020304, 0, 32'h0);
        xact(0, 1, 0, 32'h14, 32'h0,        0, 32'h01020304);

        // LAT=1: back-to-back stores and loads.
        xact(1, 0, 1, 32'h00, 32'hA5A5A5A5, 0, 32'h0);
        xact(1, 0, 1, 32'h04, 32'h5A5A5A5A, 0, 32'h0);
        xact(1, 1, 0, 32'h00, 32'h0,        0, 32'hA5A5A5A5);
        xact(1, 1, 0, 32'h04, 32'h0,        0, 32'h5A5A5A5A);
        xact(1, 1, 0, 32'h00, 32'h0,        0, 32'hA5A5A5A5);

        // LAT=5: top word, back-to-back loads, address/data wiggle during WAIT.
        xact(2, 0, 1, 32'h7C, 32'h7C7C7C7C, 0, 32'h0);
        xact(2, 0, 1, 32'h04, 32'h11111111, 0, 32'h0);
        xact(2, 1, 0, 32'h7C, 32'h0,        0, 32'h7C7C7C7C);
        xact(2, 1, 0, 32'h04, 32'h0,        0, 32'h11111111);
        xact(2, 0, 1, 32'h0C, 32'h0C0C0C0C, 0, 32'h0);
        xact(2, 0, 1, 32'h08, 32'hAAAA5555, 0, 32'h0, 1'b1);
        xact(2, 1, 0, 32'h08, 32'h0,        0, 32'hAAAA5555);
        xact(2, 1, 0, 32'h0C, 32'h0,        0, 32'h0C0C0C0C);

        // Reset in the middle of a store to 0x4 on the LAT=5 instance.
        @(posedge clk);
        #1;
        rd = '0;
        wr = '0;
        wr[2] = 1'b1;
        addr[2] = 32'h04;
        wdat[2] = 32'h22222222;
        @(negedge clk);
        @(negedge clk);
        check("mid_stall_before_rst", 32'(stall[2]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_stall", 32'(stall[2]), 32'd0);
        check("abort_ack", 32'(ack[2]), 32'd0);
        check("abort_err", 32'(err[2]), 32'd0);
        check("abort_data", dout[2], 32'd0);
        wr = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) last_d[k] = '0;
        xact(2, 1, 0, 32'h04, 32'h0, 0, 32'h11111111);
        xact(0, 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);

        // Quiet bus: nothing stalls or acks, data_o holds.
        @(posedge clk);
        #1;
        rd = '0;
        wr = '0;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check("idle_stall", 32'(stall[k]), 32'd0);
                check("idle_ack", 32'(ack[k]), 32'd0);
                check("idle_err", 32'(err[k]), 32'd0);
                check("idle_data", dout[k], last_d[k]);
            end
        end

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
